md_ctrl: RTL
============

MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  E-stage md instruction valid this cycle.
REQ-006 SHALL have port md_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved (no-op).
REQ-007 SHALL have port a  input  32  rs operand (dividend/multiplicand/mthi-mtlo source).
REQ-008 SHALL have port b  input  32  rt operand.
REQ-009 SHALL have port md_in_d  input  1  D-stage instruction is md-class (mult/div/mfhi/mflo/mthi/mtlo).
REQ-010 SHALL have port busy  output  1  unit occupied.
REQ-011 SHALL have port stall_md  output  1  stall request merged into the pipeline stall.
REQ-012 SHALL have port hi  output  32  architectural HI.
REQ-013 SHALL have port lo  output  32  architectural LO.

Function
REQ-014 SHALL implement states IDLE and RUN; count register wide enough for max(MULT_CYCLES, DIV_CYCLES).
REQ-015 SHALL, in IDLE with start and md_op 0-3, compute the 64-bit result combinationally into pending registers, load count with MULT_CYCLES (ops 0-1) or DIV_CYCLES (ops 2-3), and enter RUN at the edge.
REQ-016 SHALL decrement count each RUN cycle; at the edge where count==1, write pending to hi/lo and return to IDLE.
REQ-017 SHALL make hi/lo visible exactly N cycles after the start edge (N = MULT_CYCLES or DIV_CYCLES); hi/lo hold old values until then.
REQ-018 SHALL drive busy = start&(md_op<=3) | (state==RUN), combinationally.
REQ-019 SHALL drive stall_md = md_in_d & busy.
REQ-020 SHALL, for mthi/mtlo with start in IDLE, write a into hi/lo at the next edge, with no RUN entry and no busy assertion.
REQ-021 SHALL ignore start while in RUN (stall_md guarantees none is issued).
REQ-022 SHALL compute mult signed {hi,lo}=a*b and multu unsigned.
REQ-023 SHALL compute div lo=quotient truncated toward zero, hi=remainder with sign of dividend; divu unsigned.
REQ-024 SHALL, on div/divu with b==0, still run DIV_CYCLES but leave hi/lo unchanged.
REQ-025 SHALL, on div 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000, hi=0.
REQ-026 SHALL treat md_op 6-7 as no-op: no state change, busy low.

Reset
REQ-027 SHALL, on reset low, immediately force state IDLE, count 0, hi 0, lo 0, pending 0, independent of clk.
REQ-028 SHALL, on reset asserted mid-RUN, discard the pending result; busy and stall_md go low while reset is low.

Configuration
REQ-029 SHALL, with MD_CANCEL_EN defined, add input md_cancel (1 bit); md_cancel high in RUN returns to IDLE at the next edge without writing hi/lo; md_cancel high with start in IDLE suppresses the start (no RUN, no mthi/mtlo write).
REQ-030 SHALL, without MD_CANCEL_EN, omit md_cancel; every started operation completes.

Verification
REQ-031 SHALL verify mult a=0xFFFFFFFE (-2), b=3, MULT_CYCLES=5 -> busy high 6 cycles (start cycle + 5 RUN); hi=0xFFFFFFFF, lo=0xFFFFFFFA 5 edges after start.
REQ-032 SHALL verify divu a=7, b=2 -> lo=3, hi=1 after 10 edges; div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 SHALL verify div b=0 after mthi a=0x12345678 -> hi stays 0x12345678 after 10 cycles; busy drops.
REQ-034 SHALL verify md_in_d held high during RUN -> stall_md high every RUN cycle, low the cycle after completion; md_in_d=0 -> stall_md=0.
REQ-035 SHALL verify reset pulsed low at RUN count 3 of a mult -> hi=lo=0, busy=0 before next clk edge; later start works normally.
REQ-036 SHALL verify (MD_CANCEL_EN) md_cancel at RUN count 2 of multu 0xFFFFFFFF*2 -> state IDLE, hi/lo keep previous values.

Source files
------------

// File: rtl/md_ctrl.sv
// Multiply/divide control unit: multi-cycle occupancy model with HI/LO registers.
// Optional `MD_CANCEL_EN adds md_cancel to abort a running op or suppress a start.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_in_d,
`ifdef MD_CANCEL_EN
  input  logic        md_cancel,
`endif
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          pend_wr_q, pend_wr_d;
  logic          cancel_s;

  logic [63:0]   smul_s, umul_s;
  logic [31:0]   divisor_s, uq_s, ur_s;
  logic [31:0]   a_mag_s, b_mag_s, mq_s, mr_s, sq_s, sr_s;

`ifdef MD_CANCEL_EN
  assign cancel_s = md_cancel;
`else
  assign cancel_s = 1'b0;
`endif

  // Arithmetic datapath; signed divide works on magnitudes so 0x80000000/-1 wraps cleanly.
  always_comb begin
    smul_s    = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    umul_s    = {32'd0, a} * {32'd0, b};
    divisor_s = (b == 32'd0) ? 32'd1 : b;
    uq_s      = a / divisor_s;
    ur_s      = a % divisor_s;
    a_mag_s   = a[31] ? (32'd0 - a) : a;
    b_mag_s   = divisor_s[31] ? (32'd0 - divisor_s) : divisor_s;
    mq_s      = a_mag_s / b_mag_s;
    mr_s      = a_mag_s % b_mag_s;
    sq_s      = (a[31] ^ divisor_s[31]) ? (32'd0 - mq_s) : mq_s;
    sr_s      = a[31] ? (32'd0 - mr_s) : mr_s;
  end

  // Next-state logic for the FSM, countdown and HI/LO/pending registers.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      IDLE: begin
        if (start && !cancel_s) begin
          case (md_op)
            3'd0: begin
              pend_hi_d = smul_s[63:32];
              pend_lo_d = smul_s[31:0];
              pend_wr_d = 1'b1;
              count_d   = CW'(MULT_CYCLES);
              state_d   = RUN;
            end
            3'd1: begin
              pend_hi_d = umul_s[63:32];
              pend_lo_d = umul_s[31:0];
              pend_wr_d = 1'b1;
              count_d   = CW'(MULT_CYCLES);
              state_d   = RUN;
            end
            3'd2: begin
              pend_hi_d = sr_s;
              pend_lo_d = sq_s;
              pend_wr_d = (b != 32'd0);
              count_d   = CW'(DIV_CYCLES);
              state_d   = RUN;
            end
            3'd3: begin
              pend_hi_d = ur_s;
              pend_lo_d = uq_s;
              pend_wr_d = (b != 32'd0);
              count_d   = CW'(DIV_CYCLES);
              state_d   = RUN;
            end
            3'd4:    hi_d = a;
            3'd5:    lo_d = a;
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cancel_s) begin
          state_d   = IDLE;
          count_d   = '0;
          pend_wr_d = 1'b0;
        end else if (count_q <= CW'(1)) begin
          // Divide-by-zero completes on schedule but leaves HI/LO untouched.
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
          state_d   = IDLE;
          count_d   = '0;
          pend_wr_d = 1'b0;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // State and data registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy     = reset & ((start & (md_op <= 3'd3)) | (state_q == RUN));
  assign stall_md = md_in_d & busy;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
